// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and one-pulse key codes
// Optional build macro: KEYPAD_DIGITS_ONLY_EN (suppress DV for keys A-D, *, #)
module keypad_scanner #(
  parameter int CLKS_PER_SCAN = 1000,
  parameter int DEBOUNCE_CLKS = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_Row,
  output logic [3:0] o_Col,
  output logic       o_Keypad_DV,
  output logic [3:0] o_Keypad_Digit
);

  localparam int SCAN_W = (CLKS_PER_SCAN > 1) ? $clog2(CLKS_PER_SCAN) : 1;
  localparam int DEB_W  = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;

  localparam logic [SCAN_W-1:0] DWELL_LAST = SCAN_W'(CLKS_PER_SCAN - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_CLKS - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic [3:0]        row_meta_q, row_meta_d;
  logic [3:0]        row_sync_q, row_sync_d;
  logic [1:0]        state_q, state_d;
  logic [SCAN_W-1:0] dwell_q, dwell_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        col_q, col_d;
  logic [3:0]        pat_q, pat_d;
  logic              dv_q, dv_d;
  logic [3:0]        digit_q, digit_d;

  logic              single_low;
  logic [3:0]        row_low;
  logic [1:0]        row_idx;
  logic [3:0]        key_code;
  logic              accept_key;

  // Decode the captured row pattern and the active column into the key code
  always_comb begin
    row_low    = ~row_sync_q;
    single_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
    case (pat_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    case ({row_idx, col_q})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
`ifdef KEYPAD_DIGITS_ONLY_EN
    accept_key = (key_code <= 4'd9);
`else
    accept_key = 1'b1;
`endif
  end

  // Next-state logic: scan columns, debounce a single-row press, wait for release
  always_comb begin
    row_meta_d = i_Row;
    row_sync_d = row_meta_q;
    state_d    = state_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    pat_d      = pat_q;
    dv_d       = 1'b0;
    digit_d    = digit_q;
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (single_low) begin
            pat_d   = row_sync_q;
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (row_sync_q == pat_q) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d   = '0;
            state_d = ST_HELD;
            if (accept_key) begin
              dv_d    = 1'b1;
              digit_d = key_code;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          dwell_d = '0;
          col_d   = col_q + 2'd1;
          state_d = ST_SCAN;
        end
      end
      ST_HELD: begin
        if (row_sync_q == 4'b1111) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d   = '0;
            dwell_d = '0;
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d   = '0;
        dwell_d = '0;
        state_d = ST_SCAN;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      state_q    <= ST_SCAN;
      dwell_q    <= '0;
      cnt_q      <= '0;
      col_q      <= 2'd0;
      pat_q      <= 4'b1111;
      dv_q       <= 1'b0;
      digit_q    <= 4'd0;
    end else begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      pat_q      <= pat_d;
      dv_q       <= dv_d;
      digit_q    <= digit_d;
    end
  end

  assign o_Col          = ~(4'b0001 << col_q);
  assign o_Keypad_DV    = dv_q;
  assign o_Keypad_Digit = digit_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

  localparam int SCAN = 8;
  localparam int DEB  = 16;

  logic       i_Clk;
  logic       i_Reset;
  logic [3:0] i_Row;
  logic [3:0] o_Col;
  logic       o_Keypad_DV;
  logic [3:0] o_Keypad_Digit;

  keypad_scanner #(.CLKS_PER_SCAN(SCAN), .DEBOUNCE_CLKS(DEB)) dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_Row          (i_Row),
    .o_Col          (o_Col),
    .o_Keypad_DV    (o_Keypad_DV),
    .o_Keypad_Digit (o_Keypad_Digit)
  );

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         dv_count = 0;
  int         first_dv_cycle = -1;
  logic [3:0] last_digit = 4'd0;
  logic [3:0] exp_digit = 4'd0;
  logic [15:0] pressed = 16'd0;
  logic [3:0] got[$];
  logic [3:0] row_drive;

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Keypad matrix: a pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row_drive = 4'b1111;
    for (int i = 0; i < 16; i++)
      if (pressed[i] && !o_Col[i % 4]) row_drive[i / 4] = 1'b0;
  end
  assign i_Row = row_drive;

  function automatic logic [3:0] ref_code(input int idx);
    int r, c;
    r = idx / 4;
    c = idx % 4;
    if (c == 3) return 4'(10 + r);
    if (r == 3) return (c == 0) ? 4'hE : ((c == 1) ? 4'h0 : 4'hF);
    return 4'(r * 3 + c + 1);
  endfunction

  function automatic bit ref_emits(input int idx);
`ifdef KEYPAD_DIGITS_ONLY_EN
    return ref_code(idx) <= 4'd9;
`else
    return 1'b1;
`endif
  endfunction

  // DV of key in column c detected in the first scan round after reset
  function automatic int ref_dv_cycle(input int c);
    return SCAN * (c + 1) - 1 + DEB + 1;
  endfunction

  task automatic step();
    @(posedge i_Clk);
    @(negedge i_Clk);
    cyc++;
    if (o_Keypad_DV === 1'b1) begin
      if (dv_count == 0) first_dv_cycle = cyc;
      dv_count++;
      last_digit = o_Keypad_Digit;
      got.push_back(o_Keypad_Digit);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_mon();
    dv_count = 0;
    first_dv_cycle = -1;
    got.delete();
  endtask

  task automatic do_reset(input int n);
    @(negedge i_Clk);
    i_Reset = 1'b1;
    run(n);
    i_Reset = 1'b0;
    cyc = 0;
    exp_digit = 4'd0;
  endtask

  task automatic press_release(input int idx, input int hold);
    pressed = 16'd0;
    pressed[idx] = 1'b1;
    run(hold);
    pressed = 16'd0;
    run(2 * DEB + 10);
    if (ref_emits(idx)) exp_digit = ref_code(idx);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    pressed = 16'd0;
    clear_mon();
    do_reset(3);
    tests++;
    if (o_Col !== 4'b1110) begin fails++; $display("FAIL reset_col got=%b exp=1110", o_Col); end
    tests++;
    if (o_Keypad_DV !== 1'b0) begin fails++; $display("FAIL reset_dv got=%b exp=0", o_Keypad_DV); end
    tests++;
    if (o_Keypad_Digit !== 4'd0) begin fails++; $display("FAIL reset_digit got=%h exp=0", o_Keypad_Digit); end
    for (int i = 0; i < 40; i++) begin
      step();
      exp_col = ~(4'b0001 << ((cyc / SCAN) % 4));
      tests++;
      if (o_Col !== exp_col) begin
        fails++;
        $display("FAIL scan_col cyc=%0d got=%b exp=%b", cyc, o_Col, exp_col);
      end
    end
    tests++;
    if (dv_count !== 0) begin fails++; $display("FAIL idle_dv got=%0d exp=0", dv_count); end
  endtask

  task automatic test_hold_8();
    int col_bad;
    col_bad = 0;
    pressed = 16'd0;
    pressed[9] = 1'b1;
    clear_mon();
    do_reset(3);
    for (int i = 0; i < 500; i++) begin
      step();
      if (dv_count > 0 && o_Col !== 4'b1101) col_bad++;
    end
    pressed = 16'd0;
    run(2 * DEB + 10);
    tests++;
    if (dv_count !== 1) begin fails++; $display("FAIL hold8_count got=%0d exp=1", dv_count); end
    tests++;
    if (last_digit !== 4'd8) begin fails++; $display("FAIL hold8_digit got=%h exp=8", last_digit); end
    tests++;
    if (first_dv_cycle !== ref_dv_cycle(1)) begin
      fails++;
      $display("FAIL hold8_latency got=%0d exp=%0d", first_dv_cycle, ref_dv_cycle(1));
    end
    tests++;
    if (col_bad !== 0) begin fails++; $display("FAIL hold8_col_frozen got=%0d bad cycles exp=0", col_bad); end
    exp_digit = 4'd8;
  endtask

  task automatic test_bounce();
    clear_mon();
    pressed = 16'd0;
    pressed[5] = 1'b1;
    run(2);
    for (int t = 0; t < 6; t++) begin
      pressed[5] = ~pressed[5];
      run(2);
    end
    pressed[5] = 1'b1;
    run(200);
    pressed = 16'd0;
    run(2 * DEB + 10);
    tests++;
    if (dv_count !== 1) begin fails++; $display("FAIL bounce5_count got=%0d exp=1", dv_count); end
    tests++;
    if (last_digit !== 4'd5) begin fails++; $display("FAIL bounce5_digit got=%h exp=5", last_digit); end
    exp_digit = 4'd5;
    clear_mon();
    pressed[5] = 1'b1;
    run(10);
    pressed = 16'd0;
    run(100);
    tests++;
    if (dv_count !== 0) begin fails++; $display("FAIL glitch_count got=%0d exp=0", dv_count); end
  endtask

  task automatic test_sequence_860();
    int         combo_idx[3];
    logic [3:0] combo[3];
    logic [3:0] g;
    int         lock_pos;
    combo_idx = '{9, 6, 13};
    combo = '{4'd8, 4'd6, 4'd0};
    clear_mon();
    for (int k = 0; k < 3; k++) press_release(combo_idx[k], 80);
    tests++;
    if (dv_count !== 3) begin fails++; $display("FAIL seq_count got=%0d exp=3", dv_count); end
    lock_pos = 0;
    for (int k = 0; k < 3; k++) begin
      g = (got.size() > k) ? got[k] : 4'hx;
      tests++;
      if (g !== combo[k]) begin fails++; $display("FAIL seq_digit%0d got=%h exp=%h", k, g, combo[k]); end
    end
    foreach (got[k]) begin
      if (lock_pos < 3 && got[k] == combo[lock_pos]) lock_pos++;
      else if (lock_pos < 3) lock_pos = (got[k] == combo[0]) ? 1 : 0;
    end
    tests++;
    if (lock_pos != 3) begin fails++; $display("FAIL seq_unlocked got=%0d exp=3 digits matched", lock_pos); end
  endtask

  task automatic test_ghost_and_letter();
    logic [3:0] seen;
    seen = 4'd0;
    clear_mon();
    pressed = 16'd0;
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      for (int c = 0; c < 4; c++) if (o_Col[c] === 1'b0) seen[c] = 1'b1;
    end
    pressed = 16'd0;
    run(20);
    tests++;
    if (dv_count !== 0) begin fails++; $display("FAIL ghost_count got=%0d exp=0", dv_count); end
    tests++;
    if (seen !== 4'b1111) begin fails++; $display("FAIL ghost_scan got=%b exp=1111", seen); end
    clear_mon();
    press_release(3, 80);
    tests++;
    if (dv_count !== (ref_emits(3) ? 1 : 0)) begin
      fails++;
      $display("FAIL keyA_count got=%0d exp=%0d", dv_count, ref_emits(3) ? 1 : 0);
    end
    tests++;
    if (o_Keypad_Digit !== exp_digit) begin
      fails++;
      $display("FAIL keyA_digit got=%h exp=%h", o_Keypad_Digit, exp_digit);
    end
  endtask

  task automatic test_reset_mid_debounce();
    pressed = 16'd0;
    pressed[2] = 1'b1;
    clear_mon();
    do_reset(3);
    run(30);
    do_reset(2);
    tests++;
    if (o_Col !== 4'b1110) begin fails++; $display("FAIL midrst_col got=%b exp=1110", o_Col); end
    tests++;
    if (o_Keypad_DV !== 1'b0 || dv_count !== 0) begin
      fails++;
      $display("FAIL midrst_dv got=%b count=%0d exp=0", o_Keypad_DV, dv_count);
    end
    step();
    tests++;
    if (o_Keypad_DV !== 1'b0) begin fails++; $display("FAIL midrst_dv_after got=%b exp=0", o_Keypad_DV); end
    run(60);
    pressed = 16'd0;
    run(2 * DEB + 10);
    tests++;
    if (dv_count !== 1) begin fails++; $display("FAIL midrst_count got=%0d exp=1", dv_count); end
    tests++;
    if (last_digit !== 4'd3) begin fails++; $display("FAIL midrst_digit got=%h exp=3", last_digit); end
    tests++;
    if (first_dv_cycle !== ref_dv_cycle(2)) begin
      fails++;
      $display("FAIL midrst_latency got=%0d exp=%0d", first_dv_cycle, ref_dv_cycle(2));
    end
    exp_digit = 4'd3;
  endtask

  task automatic test_random_keys();
    int         k;
    int         exp_n;
    logic [3:0] exp_col;
    for (int it = 0; it < 20; it++) begin
      k = $urandom_range(0, 15);
      exp_n = ref_emits(k) ? 1 : 0;
      exp_col = ~(4'b0001 << (k % 4));
      clear_mon();
      pressed = 16'd0;
      pressed[k] = 1'b1;
      run(4 * SCAN + DEB + 12 + $urandom_range(0, 40));
      tests++;
      if (o_Col !== exp_col) begin
        fails++;
        $display("FAIL rnd_col key=%0d got=%b exp=%b", k, o_Col, exp_col);
      end
      pressed = 16'd0;
      run(2 * DEB + 10);
      if (exp_n == 1) exp_digit = ref_code(k);
      tests++;
      if (dv_count !== exp_n) begin
        fails++;
        $display("FAIL rnd_count key=%0d got=%0d exp=%0d", k, dv_count, exp_n);
      end
      tests++;
      if (o_Keypad_Digit !== exp_digit) begin
        fails++;
        $display("FAIL rnd_digit key=%0d got=%h exp=%h", k, o_Keypad_Digit, exp_digit);
      end
    end
  endtask

  initial begin
    i_Reset = 1'b1;
    test_reset();
    test_hold_8();
    test_bounce();
    test_sequence_860();
    test_ghost_and_letter();
    test_reset_mid_debounce();
    test_random_keys();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
